// File: rtl/smg_scan_ctrl.sv
// smg_scan_ctrl
// Multiplexed seven-segment scan controller. An internal prescaler divides
// each digit slot into SCAN_DIV cycles. Every slot starts with a blank interval
// so the digit lines never switch while segments are lit. A 4-bit PWM sets the
// brightness. A per-digit mask can blank individual digits. Display data is
// double-buffered and only committed at frame boundaries, so a frame never
// shows a mix of old and new data.

module smg_scan_ctrl #(
    parameter int DIGITS      = 6,
    parameter int SEG_W       = 8,
    parameter int SCAN_DIV    = 50000,
    parameter int BLANK_CYC   = 16,
    parameter int SEG_ACT_LOW = 0,
    parameter int DIG_ACT_LOW = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    load_i,
    input  logic [DIGITS*SEG_W-1:0] seg_data_i,
    input  logic [DIGITS-1:0]       digit_mask_i,
    input  logic [3:0]              bright_i,
    output logic [SEG_W-1:0]        seg_o,
    output logic [DIGITS-1:0]       dig_o,
    output logic                    frame_o
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DIGITS - 1);

    // Inactive level of each output bus. XOR-ing an active-high pattern with
    // this mask applies the board polarity.
    localparam logic             SEG_POL = (SEG_ACT_LOW != 0);
    localparam logic             DIG_POL = (DIG_ACT_LOW != 0);
    localparam logic [SEG_W-1:0]  SEG_OFF = {SEG_W{SEG_POL}};
    localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_POL}};

    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [DIGITS-1:0][SEG_W-1:0]   shadow_q, shadow_d;
    logic [DIGITS-1:0][SEG_W-1:0]   active_q, active_d;
    logic                           pending_q, pending_d;
    logic [SEG_W-1:0]               seg_q, seg_d;
    logic [DIGITS-1:0]              dig_q, dig_d;
    logic                           frame_q, frame_d;

    logic                           slotWrap;
    logic                           frameWrap;
    logic                           pwmOn;
    logic                           litNow;
    logic [DIGITS-1:0]              digOneHot;

    // Decode the slot/frame wrap and the lit condition from the current state
    always_comb begin
        slotWrap  = en_i && (cnt_q == CNT_MAX);
        frameWrap = slotWrap && (idx_q == IDX_MAX);
        pwmOn     = (bright_i == 4'hF) || (cnt_q[3:0] < bright_i);
        litNow    = en_i && digit_mask_i[idx_q] && (cnt_q >= BLANK_END) && pwmOn;
        digOneHot = DIGITS'(1) << idx_q;
    end

    // Next-state: scan position, double buffer and registered pin drive
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        frame_d   = 1'b0;
        seg_d     = SEG_OFF;
        dig_d     = DIG_OFF;

        if (!en_i) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (slotWrap) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // The commit reads the pre-edge shadow, so a load that coincides with
        // the wrap is held as pending for the following frame.
        if (frameWrap) begin
            frame_d = 1'b1;
            if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end

        if (load_i) begin
            shadow_d  = seg_data_i;
            pending_d = 1'b1;
        end

        if (litNow) begin
            seg_d = active_q[idx_q] ^ SEG_OFF;
            dig_d = digOneHot ^ DIG_OFF;
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            seg_q     <= SEG_OFF;
            dig_q     <= DIG_OFF;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            dig_q     <= dig_d;
            frame_q   <= frame_d;
        end
    end

    assign seg_o   = seg_q;
    assign dig_o   = dig_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// tb_smg_scan_ctrl
// Directed bench for smg_scan_ctrl (3 digits, 32-cycle slots, 4 blank cycles).
// The stimulus process queues hand-computed expectations, each tagged with
// the clock edge it refers to. A monitor samples the outputs on every falling
// edge and checks each expectation once its edge has been reached.

module tb_smg_scan_ctrl;

    localparam int DIGITS    = 3;
    localparam int SEG_W     = 8;
    localparam int SCAN_DIV  = 32;
    localparam int BLANK_CYC = 4;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    en_i;
    logic                    load_i;
    logic [DIGITS*SEG_W-1:0] seg_data_i;
    logic [DIGITS-1:0]       digit_mask_i;
    logic [3:0]              bright_i;
    logic [SEG_W-1:0]        seg_o;
    logic [DIGITS-1:0]       dig_o;
    logic                    frame_o;

    typedef struct {
        int               tcyc;
        logic [SEG_W-1:0] seg;
        logic [2:0]       dig;
        logic             frame;
        string            name;
    } expect_t;

    expect_t sb[$];
    int      cyc     = 0;
    int      t0      = 0;
    int      nChecks = 0;
    int      nPassed = 0;

    smg_scan_ctrl #(
        .DIGITS      (DIGITS),
        .SEG_W       (SEG_W),
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYC   (BLANK_CYC),
        .SEG_ACT_LOW (0),
        .DIG_ACT_LOW (1)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .load_i       (load_i),
        .seg_data_i   (seg_data_i),
        .digit_mask_i (digit_mask_i),
        .bright_i     (bright_i),
        .seg_o        (seg_o),
        .dig_o        (dig_o),
        .frame_o      (frame_o)
    );

    // Free-running clock
    always #5 clk_i = ~clk_i;

    // Edge counter used to timestamp expectations
    always @(posedge clk_i) cyc <= cyc + 1;

    // Queue an expectation for edge t0+k
    task automatic expectOutput(input int k, input logic [7:0] seg, input logic [2:0] dig,
                                input logic frame, input string name);
        expect_t e;
        e.tcyc  = t0 + k;
        e.seg   = seg;
        e.dig   = dig;
        e.frame = frame;
        e.name  = name;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input expect_t e);
        nChecks++;
        if (seg_o === e.seg && dig_o === e.dig && frame_o === e.frame) begin
            nPassed++;
        end else begin
            $display("[TB] FAIL %s @edge %0d: got seg=%h dig=%b frame=%b, expected seg=%h dig=%b frame=%b",
                     e.name, e.tcyc, seg_o, dig_o, frame_o, e.seg, e.dig, e.frame);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic load, input logic [23:0] data,
                                 input logic [2:0] mask, input logic [3:0] bright);
        en_i         = en;
        load_i       = load;
        seg_data_i   = data;
        digit_mask_i = mask;
        bright_i     = bright;
    endtask

    task automatic waitCyc(input int target);
        while (cyc < target) @(negedge clk_i);
    endtask

    // Monitor: compare every expectation whose edge has been reached
    always @(negedge clk_i) begin
        while (sb.size() > 0 && sb[0].tcyc <= cyc) begin
            expect_t e;
            e = sb.pop_front();
            if (e.tcyc < cyc) begin
                nChecks++;
                $display("[TB] FAIL %s: sampled late at edge %0d, required edge %0d", e.name, cyc, e.tcyc);
            end else begin
                checkOutput(e);
            end
        end
    end

    // Safety net against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached with %0d expectations outstanding", sb.size());
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus with hand-computed expectations
    initial begin
        applyStimulus(1'b0, 1'b0, 24'h0, 3'b000, 4'h0);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);

        // Reset release while disabled: idle outputs, no frame pulses
        t0    = cyc;
        rst_i = 1'b1;
        expectOutput(1,  8'h00, 3'b111, 1'b0, "reset_idle_1");
        expectOutput(5,  8'h00, 3'b111, 1'b0, "reset_idle_5");
        expectOutput(12, 8'h00, 3'b111, 1'b0, "reset_idle_12");
        waitCyc(t0 + 12);

        // Enable with a load; data appears only after the first frame pulse
        applyStimulus(1'b1, 1'b1, {8'h5B, 8'h06, 8'h3F}, 3'b111, 4'hF);
        t0 = cyc;
        expectOutput(1,   8'h00, 3'b111, 1'b0, "first_slot_blank");
        expectOutput(95,  8'h00, 3'b011, 1'b0, "pre_wrap_old_data");
        expectOutput(96,  8'h00, 3'b011, 1'b1, "first_frame_pulse");
        expectOutput(97,  8'h00, 3'b111, 1'b0, "frame_pulse_one_cycle");
        expectOutput(100, 8'h00, 3'b111, 1'b0, "blank_interval_end");
        expectOutput(101, 8'h3F, 3'b110, 1'b0, "d0_first_lit");
        expectOutput(128, 8'h3F, 3'b110, 1'b0, "d0_last_lit");
        expectOutput(129, 8'h00, 3'b111, 1'b0, "d1_slot_blank");
        expectOutput(133, 8'h06, 3'b101, 1'b0, "d1_first_lit");
        expectOutput(165, 8'h5B, 3'b011, 1'b0, "d2_first_lit");
        expectOutput(192, 8'h5B, 3'b011, 1'b1, "second_frame_pulse");
        @(negedge clk_i);
        load_i = 1'b0;
        waitCyc(t0 + 192);

        // Half brightness: lit on cnt 4..7 and 16..23 of the digit-0 slot
        bright_i = 4'h8;
        expectOutput(198, 8'h3F, 3'b110, 1'b0, "pwm8_cnt5_lit");
        expectOutput(201, 8'h00, 3'b111, 1'b0, "pwm8_cnt8_dark");
        expectOutput(209, 8'h3F, 3'b110, 1'b0, "pwm8_cnt16_lit");
        expectOutput(216, 8'h3F, 3'b110, 1'b0, "pwm8_cnt23_lit");
        expectOutput(217, 8'h00, 3'b111, 1'b0, "pwm8_cnt24_dark");
        waitCyc(t0 + 224);

        // Zero brightness is fully dark
        bright_i = 4'h0;
        expectOutput(230, 8'h00, 3'b111, 1'b0, "pwm0_cnt5_dark");
        expectOutput(240, 8'h00, 3'b111, 1'b0, "pwm0_cnt15_dark");
        waitCyc(t0 + 256);

        // Mask out digit 1; its slot stays blank but still takes 32 cycles
        bright_i     = 4'hF;
        digit_mask_i = 3'b101;
        expectOutput(270, 8'h5B, 3'b011, 1'b0, "mask_d2_lit");
        expectOutput(288, 8'h5B, 3'b011, 1'b1, "mask_frame_pulse");
        expectOutput(300, 8'h3F, 3'b110, 1'b0, "mask_d0_lit");
        expectOutput(330, 8'h00, 3'b111, 1'b0, "mask_d1_blank");
        expectOutput(352, 8'h00, 3'b111, 1'b0, "mask_d1_end_blank");
        expectOutput(353, 8'h00, 3'b111, 1'b0, "mask_d2_start_blank");
        expectOutput(360, 8'h5B, 3'b011, 1'b0, "mask_d2_lit_again");
        expectOutput(384, 8'h5B, 3'b011, 1'b1, "mask_frame_period");
        waitCyc(t0 + 400);

        // Mid-frame load B, then X and D back to back, then C on the wrap edge
        digit_mask_i = 3'b111;
        load_i       = 1'b1;
        seg_data_i   = {8'h4F, 8'h66, 8'h6D};
        expectOutput(430, 8'h06, 3'b101, 1'b0, "load_b_not_yet_d1");
        expectOutput(470, 8'h5B, 3'b011, 1'b0, "load_b_not_yet_d2");
        expectOutput(480, 8'h5B, 3'b011, 1'b1, "load_b_wrap_old");
        expectOutput(490, 8'h6D, 3'b110, 1'b0, "b_d0");
        expectOutput(530, 8'h66, 3'b101, 1'b0, "b_d1_after_new_load");
        expectOutput(570, 8'h4F, 3'b011, 1'b0, "b_d2_after_new_load");
        expectOutput(576, 8'h4F, 3'b011, 1'b1, "wrap_load_frame");
        expectOutput(590, 8'h7F, 3'b110, 1'b0, "last_load_wins_d0");
        expectOutput(630, 8'h07, 3'b101, 1'b0, "d_d1");
        expectOutput(660, 8'h7D, 3'b011, 1'b0, "d_d2");
        expectOutput(672, 8'h7D, 3'b011, 1'b1, "wrap_load_commit_frame");
        expectOutput(690, 8'h79, 3'b110, 1'b0, "c_d0");
        expectOutput(730, 8'h5E, 3'b101, 1'b0, "c_d1");
        @(negedge clk_i);
        load_i = 1'b0;
        waitCyc(t0 + 500);
        load_i     = 1'b1;
        seg_data_i = {8'h11, 8'h22, 8'h33};
        @(negedge clk_i);
        seg_data_i = {8'h7D, 8'h07, 8'h7F};
        @(negedge clk_i);
        load_i = 1'b0;
        waitCyc(t0 + 575);
        load_i     = 1'b1;
        seg_data_i = {8'h39, 8'h5E, 8'h79};
        @(negedge clk_i);
        load_i = 1'b0;
        waitCyc(t0 + 745);

        // Drop enable mid-slot: blank on the very next edge
        expectOutput(750, 8'h39, 3'b011, 1'b0, "c_d2_before_disable");
        expectOutput(751, 8'h00, 3'b111, 1'b0, "disable_blank");
        expectOutput(760, 8'h00, 3'b111, 1'b0, "disable_hold");
        waitCyc(t0 + 750);
        en_i = 1'b0;
        waitCyc(t0 + 770);

        // Re-enable: digit 0 lights at edge 5 with retained data
        en_i = 1'b1;
        t0   = cyc;
        expectOutput(4,  8'h00, 3'b111, 1'b0, "resume_blank");
        expectOutput(5,  8'h79, 3'b110, 1'b0, "resume_d0_lit");
        expectOutput(20, 8'h79, 3'b110, 1'b0, "pre_reset_lit");
        expectOutput(21, 8'h00, 3'b111, 1'b0, "async_reset_blank");
        waitCyc(t0 + 20);

        // Reset pulse between edges must blank outputs before the next edge
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        t0 = cyc;
        expectOutput(1,   8'h00, 3'b111, 1'b0, "post_reset_blank");
        expectOutput(5,   8'h00, 3'b110, 1'b0, "post_reset_data_cleared");
        expectOutput(96,  8'h00, 3'b011, 1'b1, "post_reset_frame");
        expectOutput(101, 8'h00, 3'b110, 1'b0, "post_reset_no_commit");
        waitCyc(t0 + 101);

        repeat (10) begin
            if (sb.size() > 0) @(negedge clk_i);
        end
        while (sb.size() > 0) begin
            expect_t e;
            e = sb.pop_front();
            nChecks++;
            $display("[TB] FAIL %s: edge %0d never sampled", e.name, e.tcyc);
        end

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
